// File: rtl/immediate_generator.sv
// RV32I immediate extension for the decode stage.
// Produces the 32-bit operand combinationally from the right-aligned raw
// immediate field and the opcode, plus a one-stage registered copy for
// pipelined consumers.
module immediate_generator (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic        in_valid,
    output logic [31:0] ex_imm,
    output logic [2:0]  imm_fmt,
    output logic [31:0] ex_imm_q,
    output logic [2:0]  imm_fmt_q,
    output logic        out_valid
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_ENV    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    fmt_e fmt;

    // Decode the opcode into an immediate format; anything unlisted is NONE.
    always_comb begin
        // NOTE: every always_comb output gets a default before the case so no
        // path leaves it unassigned (which would infer a latch); an X or
        // unlisted opcode also lands on this default, keeping X off ex_imm.
        fmt = FMT_NONE;
        case (opcode)
            OP_LOAD, OP_ITYPE, OP_JALR, OP_FENCE, OP_ENV: fmt = FMT_I;
            OP_STORE:                                     fmt = FMT_S;
            OP_BRANCH:                                    fmt = FMT_B;
            OP_LUI, OP_AUIPC:                             fmt = FMT_U;
            OP_JAL:                                       fmt = FMT_J;
            default:                                      fmt = FMT_NONE;
        endcase
    end

    // Extend the raw field according to the decoded format; bits above the
    // used field never reach the result.
    always_comb begin
        ex_imm = 32'h0000_0000;
        case (fmt)
            FMT_I, FMT_S: ex_imm = {{20{imm[11]}}, imm[11:0]};
            FMT_B:        ex_imm = {{19{imm[12]}}, imm[12:0]};
            FMT_U:        ex_imm = {imm[19:0], 12'h000};
            FMT_J:        ex_imm = {{11{imm[20]}}, imm[20:0]};
            default:      ex_imm = 32'h0000_0000;
        endcase
    end

    assign imm_fmt = fmt;

    // Pipeline register: capture on in_valid, hold otherwise; reset wins.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            ex_imm_q  <= 32'h0000_0000;
            imm_fmt_q <= FMT_NONE;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                ex_imm_q  <= ex_imm;
                imm_fmt_q <= fmt;
            end
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_immediate_generator.sv
// Directed bench for immediate_generator: combinational decode/extension
// vectors followed by the registered stage (capture, hold, reset priority).
module tb_immediate_generator;

    logic        clk;
    logic        reset;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic        in_valid;
    logic [31:0] ex_imm;
    logic [2:0]  imm_fmt;
    logic [31:0] ex_imm_q;
    logic [2:0]  imm_fmt_q;
    logic        out_valid;

    int checks;
    int fails;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_ENV    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    immediate_generator dut (
        .clk       (clk),
        .reset     (reset),
        .imm       (imm),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .ex_imm    (ex_imm),
        .imm_fmt   (imm_fmt),
        .ex_imm_q  (ex_imm_q),
        .imm_fmt_q (imm_fmt_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Apply one combinational vector and compare both outputs.
    task automatic comb_vec(input string tag, input logic [6:0] op, input logic [31:0] raw,
                            input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
        opcode = op;
        imm    = raw;
        #1;
        check({tag, ".ex_imm"}, ex_imm, exp_imm);
        check({tag, ".imm_fmt"}, {29'd0, imm_fmt}, {29'd0, exp_fmt});
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = 7'd0;
        imm      = 32'd0;

        // Reset state of the registered stage.
        @(posedge clk); #1;
        check("rst.ex_imm_q", ex_imm_q, 32'h0);
        check("rst.imm_fmt_q", {29'd0, imm_fmt_q}, 32'd0);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);

        // Combinational path, exercised while reset is still high.
        comb_vec("i_jalr",  OP_JALR,  32'd1972,     32'h0000_07B4, 3'd1);
        comb_vec("i_load",  OP_LOAD,  -32'sd1121,   32'hFFFF_FB9F, 3'd1);
        comb_vec("i_itype", OP_ITYPE, 32'd310,      32'h0000_0136, 3'd1);
        comb_vec("i_fence", OP_FENCE, 32'd0,        32'h0000_0000, 3'd1);
        comb_vec("i_env",   OP_ENV,   -32'sd2025,   32'hFFFF_F817, 3'd1);
        comb_vec("i_upper", OP_LOAD,  32'h1234_5800, 32'hFFFF_F800, 3'd1);
        comb_vec("s_pos",   OP_STORE, 32'd1972,     32'h0000_07B4, 3'd2);
        comb_vec("s_neg",   OP_STORE, -32'sd1121,   32'hFFFF_FB9F, 3'd2);
        comb_vec("s_upper", OP_STORE, 32'hFFFF_F07F, 32'h0000_007F, 3'd2);
        comb_vec("u_lui",   OP_LUI,   32'h0000_BEEF, 32'h0BEE_F000, 3'd4);
        comb_vec("u_auipc", OP_AUIPC, 32'hDEAD_BEEF, 32'hDBEE_F000, 3'd4);
        comb_vec("b_pos",   OP_BRANCH, 32'd1972,    32'h0000_07B4, 3'd3);
        comb_vec("b_neg",   OP_BRANCH, -32'sd1121,  32'hFFFF_FB9F, 3'd3);
        comb_vec("b_bit12", OP_BRANCH, 32'h0000_1000, 32'hFFFF_F000, 3'd3);
        comb_vec("b_bit11", OP_BRANCH, 32'hFFFF_E800, 32'h0000_0800, 3'd3);
        comb_vec("j_pos",   OP_JAL,   32'd1972,     32'h0000_07B4, 3'd5);
        comb_vec("j_neg",   OP_JAL,   -32'sd1121,   32'hFFFF_FB9F, 3'd5);
        comb_vec("j_bit20", OP_JAL,   32'h0010_0000, 32'hFFF0_0000, 3'd5);
        comb_vec("j_bit19", OP_JAL,   32'hFFE8_0000, 32'h0008_0000, 3'd5);
        comb_vec("n_rpos",  OP_RTYPE, 32'd1972,     32'h0000_0000, 3'd0);
        comb_vec("n_rneg",  OP_RTYPE, -32'sd1121,   32'h0000_0000, 3'd0);
        comb_vec("n_undef", 7'b1111111, 32'hFFFF_FFFF, 32'h0000_0000, 3'd0);
        comb_vec("n_xop",   7'bxxxxxxx, 32'hFFFF_FFFF, 32'h0000_0000, 3'd0);

        // Registers stay cleared while reset is held, even with in_valid.
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = OP_LUI;
        imm      = 32'h0000_BEEF;
        @(posedge clk); #1;
        check("rst_hold.ex_imm_q", ex_imm_q, 32'h0);
        check("rst_hold.out_valid", {31'd0, out_valid}, 32'd0);

        // Capture on in_valid after reset release.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("cap.ex_imm_q", ex_imm_q, 32'h0BEE_F000);
        check("cap.imm_fmt_q", {29'd0, imm_fmt_q}, 32'd4);
        check("cap.out_valid", {31'd0, out_valid}, 32'd1);

        // Hold when in_valid drops, while the combinational path follows input.
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = OP_STORE;
        imm      = 32'd5;
        @(posedge clk); #1;
        check("hold.ex_imm_q", ex_imm_q, 32'h0BEE_F000);
        check("hold.imm_fmt_q", {29'd0, imm_fmt_q}, 32'd4);
        check("hold.out_valid", {31'd0, out_valid}, 32'd0);
        check("hold.ex_imm", ex_imm, 32'h0000_0005);

        // A second capture with a different format.
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = OP_JAL;
        imm      = 32'h0010_0000;
        @(posedge clk); #1;
        check("cap2.ex_imm_q", ex_imm_q, 32'hFFF0_0000);
        check("cap2.imm_fmt_q", {29'd0, imm_fmt_q}, 32'd5);
        check("cap2.out_valid", {31'd0, out_valid}, 32'd1);

        // Reset mid-stream together with in_valid: reset wins, comb stays live.
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        opcode   = OP_ITYPE;
        imm      = 32'd310;
        @(posedge clk); #1;
        check("rst_mid.ex_imm_q", ex_imm_q, 32'h0);
        check("rst_mid.imm_fmt_q", {29'd0, imm_fmt_q}, 32'd0);
        check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid.ex_imm", ex_imm, 32'h0000_0136);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/immediate_generator.md
Name: immediate_generator

Overview:
Combinational RV32I immediate sign/zero-extension unit in the decode stage. It takes the raw immediate field from the instruction decoder (right-aligned, unextended) plus the 7-bit opcode, and produces the 32-bit operand used by the ALU, branch and jump logic. The combinational result drives ex_imm with zero latency. A one-stage registered copy (ex_imm_q, imm_fmt_q, out_valid) is also provided for pipelined consumers.

Parameters:
None (XLEN fixed at 32).

Ports:
clk  input  1  system clock; all registered outputs update on rising edge
reset  input  1  synchronous, active-high reset
imm  input  32  raw immediate field from decoder, right-aligned (I/S: [11:0], B: [12:0] with bit0=0, J: [20:0] with bit0=0, U: [19:0] = instr[31:12])
opcode  input  7  instruction opcode (instr[6:0])
in_valid  input  1  qualifies imm/opcode for the registered stage
ex_imm  output  32  combinational extended immediate
imm_fmt  output  3  combinational format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
ex_imm_q  output  32  registered ex_imm
imm_fmt_q  output  3  registered imm_fmt
out_valid  output  1  registered in_valid

Behaviour:
- Opcode map, all other opcodes are NONE:
  - I: LOAD 0000011, ITYPE 0010011, JALR 1100111, FENCE 0001111, ENVIRONMENT 1110011
  - S: STORE 0100011
  - B: BRANCH 1100011
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - NONE: RTYPE 0110011 and every unlisted opcode
- ex_imm, purely combinational, same delta as inputs:
  - I and S: sign-extend imm[11:0] (bit 11 replicated into [31:12]).
  - B: sign-extend imm[12:0] (bit 12 replicated into [31:13]). imm[0] is passed through unmodified.
  - U: {imm[19:0], 12'b0}. imm[31:20] is ignored.
  - J: sign-extend imm[20:0] (bit 20 replicated into [31:21]). imm[0] is passed through.
  - NONE: 32'h0000_0000.
- Input bits above the used field are ignored for every format.
- imm_fmt is combinational and follows the same decode.
- Registered stage, on posedge clk:
  - If reset: ex_imm_q=0, imm_fmt_q=0, out_valid=0.
  - Else if in_valid: ex_imm_q<=ex_imm, imm_fmt_q<=imm_fmt.
  - Else: hold ex_imm_q and imm_fmt_q.
  - out_valid<=in_valid every non-reset cycle.
- Latency: ex_imm and imm_fmt have 0 cycles; the _q outputs and out_valid have 1 cycle.
- Reset asserted mid-stream clears the _q outputs and out_valid on that edge. ex_imm stays live during reset.
- Reset takes priority over in_valid on the same edge.
- No X propagation: an unknown opcode yields 0 / NONE.

Test Plan:
- I-type: imm=1972 with JALR -> ex_imm=0x000007B4. imm=-1121 with LOAD -> 0xFFFFFB9F. imm=310 with ITYPE -> 0x00000136. imm=0 with FENCE -> 0. imm=-2025 with ENVIRONMENT -> 0xFFFFF817. imm_fmt=1 for all.
- S-type, STORE: imm=1972 -> 0x000007B4. imm=-1121 -> 0xFFFFFB9F. imm_fmt=2.
- U-type: LUI with imm=0x0000BEEF -> 0x0BEEF000. AUIPC with imm=0xDEADBEEF -> 0xDBEEF000 (upper bits ignored). imm_fmt=4.
- B/J: BRANCH with imm=1972 -> 0x000007B4, with imm=-1121 -> 0xFFFFFB9F (imm_fmt=3). JAL with the same two values -> 0x000007B4 and 0xFFFFFB9F (imm_fmt=5).
- NONE: RTYPE with imm=1972 and with imm=-1121 -> ex_imm=0, imm_fmt=0. An undefined opcode 7'b1111111 -> 0.
- Registered stage:
  - Assert reset for 1 clk -> all _q outputs and out_valid are 0.
  - in_valid=1 with LUI, imm=0xBEEF -> next edge gives ex_imm_q=0x0BEEF000, imm_fmt_q=4, out_valid=1.
  - in_valid=0 with the opcode changed -> _q outputs hold and out_valid=0.
  - Reset together with in_valid=1 -> outputs cleared.
